// File: rtl/exec_pipe_regbank.sv
// Register bank plus two-stage ALU execute pipeline with operand forwarding,
// a host write port that overrides writeback, and a saturating retire counter.
module exec_pipe_regbank #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned ZERO_R0 = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_we,
    input  logic [AW-1:0]    host_dr,
    input  logic [WIDTH-1:0] host_data,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [3:0]       iss_mode,
    input  logic [AW-1:0]    iss_sr1,
    input  logic [AW-1:0]    iss_sr2,
    input  logic [AW-1:0]    iss_dr,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_dr,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_zero,
    output logic             wb_carry,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [15:0]      op_count
);
    localparam int unsigned SW = $clog2(WIDTH);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             ex_valid_q, ex_valid_d;
    logic [3:0]       ex_mode_q, ex_mode_d;
    logic [AW-1:0]    ex_dr_q, ex_dr_d;
    logic [WIDTH-1:0] ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;

    logic             wb_valid_q, wb_valid_d;
    logic             wb_fwd_q, wb_fwd_d;
    logic [AW-1:0]    wb_dr_q, wb_dr_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             wb_zero_q, wb_zero_d, wb_carry_q, wb_carry_d;
    logic [15:0]      op_count_q, op_count_d;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH:0]   alu_sum, alu_diff;
    logic [SW-1:0]    alu_shamt;
    logic [WIDTH-1:0] op1_sel, op2_sel;

    // Source priority: hardwired zero, then EX result, then WB result, then regfile.
    function automatic logic [WIDTH-1:0] pick_operand(
        input logic [AW-1:0]    src,
        input logic [WIDTH-1:0] rf_val,
        input logic             ex_hit,
        input logic [WIDTH-1:0] ex_val,
        input logic             wb_hit,
        input logic [WIDTH-1:0] wb_val
    );
        if ((ZERO_R0 != 0) && (src == {AW{1'b0}})) begin
            return {WIDTH{1'b0}};
        end else if (ex_hit) begin
            return ex_val;
        end else if (wb_hit) begin
            return wb_val;
        end else begin
            return rf_val;
        end
    endfunction

    assign iss_ready = ~host_we;
    assign accept    = iss_valid & iss_ready;

    // ALU on the EX-stage operands.
    always_comb begin
        alu_sum   = {1'b0, ex_op1_q} + {1'b0, ex_op2_q};
        alu_diff  = {1'b0, ex_op1_q} + {1'b0, ~ex_op2_q} + {{WIDTH{1'b0}}, 1'b1};
        alu_shamt = ex_op2_q[SW-1:0];
        alu_res   = {WIDTH{1'b0}};
        alu_carry = 1'b0;
        case (ex_mode_q)
            4'd0:  begin alu_res = alu_sum[WIDTH-1:0];  alu_carry = alu_sum[WIDTH];  end
            4'd1:  begin alu_res = alu_diff[WIDTH-1:0]; alu_carry = alu_diff[WIDTH]; end
            4'd2:  alu_res = ex_op1_q & ex_op2_q;
            4'd3:  alu_res = ex_op1_q | ex_op2_q;
            4'd4:  alu_res = ex_op1_q ^ ex_op2_q;
            4'd5:  alu_res = ~ex_op1_q;
            4'd6:  alu_res = ex_op1_q << alu_shamt;
            4'd7:  alu_res = ex_op1_q >> alu_shamt;
            4'd8:  alu_res = $unsigned($signed(ex_op1_q) >>> alu_shamt);
            4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(ex_op1_q) < $signed(ex_op2_q))};
            4'd10: alu_res = {{(WIDTH-1){1'b0}}, (ex_op1_q < ex_op2_q)};
            4'd11: alu_res = ex_op2_q;
            default: alu_res = {WIDTH{1'b0}};
        endcase
    end

    // Operand read with forwarding at the issue edge.
    always_comb begin
        op1_sel = pick_operand(iss_sr1, regs_q[iss_sr1],
                               ex_valid_q && (ex_dr_q == iss_sr1), alu_res,
                               wb_valid_q && wb_fwd_q && (wb_dr_q == iss_sr1), wb_data_q);
        op2_sel = pick_operand(iss_sr2, regs_q[iss_sr2],
                               ex_valid_q && (ex_dr_q == iss_sr2), alu_res,
                               wb_valid_q && wb_fwd_q && (wb_dr_q == iss_sr2), wb_data_q);
    end

    // Pipeline next-state; a host write to the EX destination drops its WB forward.
    always_comb begin
        ex_valid_d = accept;
        ex_mode_d  = ex_mode_q;
        ex_dr_d    = ex_dr_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        if (accept) begin
            ex_mode_d = iss_mode;
            ex_dr_d   = iss_dr;
            ex_op1_d  = op1_sel;
            ex_op2_d  = op2_sel;
        end else begin
            ex_mode_d = ex_mode_q;
        end

        wb_valid_d = ex_valid_q;
        wb_fwd_d   = ex_valid_q & ~(host_we & (host_dr == ex_dr_q));
        wb_dr_d    = wb_dr_q;
        wb_data_d  = wb_data_q;
        wb_zero_d  = wb_zero_q;
        wb_carry_d = wb_carry_q;
        if (ex_valid_q) begin
            wb_dr_d    = ex_dr_q;
            wb_data_d  = alu_res;
            wb_zero_d  = (alu_res == {WIDTH{1'b0}});
            wb_carry_d = alu_carry;
        end else begin
            wb_dr_d = wb_dr_q;
        end

        if (wb_valid_q && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end else begin
            op_count_d = op_count_q;
        end
    end

    // Regfile next-state; host write applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wb_valid_q && !((ZERO_R0 != 0) && (wb_dr_q == {AW{1'b0}}))) begin
            regs_d[wb_dr_q] = wb_data_q;
        end else begin
            regs_d[0] = regs_q[0];
        end
        if (host_we && !((ZERO_R0 != 0) && (host_dr == {AW{1'b0}}))) begin
            regs_d[host_dr] = host_data;
        end else begin
            regs_d[0] = regs_d[0];
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            ex_valid_q <= 1'b0;
            ex_mode_q  <= 4'd0;
            ex_dr_q    <= {AW{1'b0}};
            ex_op1_q   <= {WIDTH{1'b0}};
            ex_op2_q   <= {WIDTH{1'b0}};
            wb_valid_q <= 1'b0;
            wb_fwd_q   <= 1'b0;
            wb_dr_q    <= {AW{1'b0}};
            wb_data_q  <= {WIDTH{1'b0}};
            wb_zero_q  <= 1'b0;
            wb_carry_q <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            regs_q     <= regs_d;
            ex_valid_q <= ex_valid_d;
            ex_mode_q  <= ex_mode_d;
            ex_dr_q    <= ex_dr_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            wb_valid_q <= wb_valid_d;
            wb_fwd_q   <= wb_fwd_d;
            wb_dr_q    <= wb_dr_d;
            wb_data_q  <= wb_data_d;
            wb_zero_q  <= wb_zero_d;
            wb_carry_q <= wb_carry_d;
            op_count_q <= op_count_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_dr    = wb_dr_q;
    assign wb_data  = wb_data_q;
    assign wb_zero  = wb_zero_q;
    assign wb_carry = wb_carry_q;
    assign op_count = op_count_q;
    assign dbg_data = regs_q[dbg_addr];
endmodule
